// File: rtl/pcie_us_cq_reg_completer.sv
// Completer for the UltraScale+ PCIe CQ/CC streams backed by a small
// BAR-mapped 32-bit register file. Single-DW MRd/MWr are served; every
// other request is drained, and non-posted ones are answered with UR.
//
// Handshake: a beat moves on CQ or CC only in a cycle where tvalid and tready
// are both high at the rising edge; CC holds all outputs stable while waiting.
module pcie_us_cq_reg_completer #(
    parameter int          AXIS_PCIE_DATA_WIDTH    = 256,
    parameter int          AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
    parameter int          AXIS_PCIE_CQ_USER_WIDTH = 88,
    parameter int          AXIS_PCIE_CC_USER_WIDTH = 33,
    parameter int          REG_COUNT               = 16,
    parameter logic [31:0] ID_VALUE                = 32'h1234_0001
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [AXIS_PCIE_DATA_WIDTH-1:0]    s_axis_cq_tdata,
    input  logic [AXIS_PCIE_KEEP_WIDTH-1:0]    s_axis_cq_tkeep,
    input  logic                               s_axis_cq_tlast,
    input  logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] s_axis_cq_tuser,
    input  logic                               s_axis_cq_tvalid,
    output logic                               s_axis_cq_tready,
    output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_cc_tdata,
    output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_cc_tkeep,
    output logic                               m_axis_cc_tlast,
    output logic [AXIS_PCIE_CC_USER_WIDTH-1:0] m_axis_cc_tuser,
    output logic                               m_axis_cc_tvalid,
    input  logic                               m_axis_cc_tready,
    output logic [32*REG_COUNT-1:0]            reg_out,
    output logic                               status_error_uncor
);

    localparam int IDX_W = $clog2(REG_COUNT);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_READ, S_CPL} state_t;
    state_t state, state_next;

    logic [31:0] regs [REG_COUNT];

    // Beat-0 descriptor decode
    logic [IDX_W-1:0] cq_idx;
    logic [3:0]       cq_type;
    logic [10:0]      cq_dw;
    logic             cq_is_mwr, cq_is_mrd, cq_single, cq_ok_wr, cq_ok_rd;
    logic             cq_fire, beat0_fire;

    assign cq_idx     = s_axis_cq_tdata[2 +: IDX_W];
    assign cq_type    = s_axis_cq_tdata[78:75];
    assign cq_dw      = s_axis_cq_tdata[74:64];
    assign cq_is_mwr  = (cq_type == 4'b0001);
    assign cq_is_mrd  = (cq_type == 4'b0000);
    assign cq_single  = (cq_dw == 11'd1) && s_axis_cq_tlast;
    assign cq_ok_wr   = cq_is_mwr && cq_single;
    assign cq_ok_rd   = cq_is_mrd && cq_single;
    assign cq_fire    = s_axis_cq_tvalid && s_axis_cq_tready;
    assign beat0_fire = cq_fire && (state == S_IDLE);

    // Descriptor bits not needed by this completer
    logic unused_inputs;
    assign unused_inputs = ^{s_axis_cq_tkeep, s_axis_cq_tuser, s_axis_cq_tdata};

    // Request context held for the completion
    logic [15:0]      rid_q;
    logic [7:0]       tag_q, func_q;
    logic [2:0]       tc_q, attr_q;
    logic [4:0]       la_q;
    logic [3:0]       be_q;
    logic [IDX_W-1:0] idx_q;
    logic             ur_q;
    logic [31:0]      rd_data_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (beat0_fire) begin
                    if (!s_axis_cq_tlast) state_next = S_DRAIN;
                    else if (cq_ok_rd)    state_next = S_READ;
                    else if (!cq_is_mwr)  state_next = S_CPL;
                    else                  state_next = S_IDLE;
                end
            end
            S_DRAIN: if (cq_fire && s_axis_cq_tlast) state_next = ur_q ? S_CPL : S_IDLE;
            S_READ:  state_next = S_CPL;
            S_CPL:   if (m_axis_cc_tready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Capture request context on beat 0, read data in READ
    always_ff @(posedge clk) begin
        if (rst) begin
            ur_q      <= 1'b0;
            rd_data_q <= '0;
        end else begin
            if (beat0_fire) begin
                rid_q  <= s_axis_cq_tdata[95:80];
                tag_q  <= s_axis_cq_tdata[103:96];
                func_q <= s_axis_cq_tdata[111:104];
                tc_q   <= s_axis_cq_tdata[123:121];
                attr_q <= s_axis_cq_tdata[126:124];
                la_q   <= s_axis_cq_tdata[6:2];
                be_q   <= s_axis_cq_tuser[3:0];
                idx_q  <= cq_idx;
                // UR only for non-posted requests that are not a plain single-DW read
                ur_q   <= !cq_is_mwr && !cq_ok_rd;
            end
            if (state == S_READ)
                rd_data_q <= (idx_q == '0) ? ID_VALUE : regs[idx_q];
        end
    end

    // Register file: byte-masked single-DW writes; reg0 is read-only
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (beat0_fire && cq_ok_wr && cq_idx != '0) begin
            for (int b = 0; b < 4; b++)
                if (s_axis_cq_tuser[b]) regs[cq_idx][8*b +: 8] <= s_axis_cq_tdata[128 + 8*b +: 8];
        end
    end

    // Flattened register view
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++)
            reg_out[i*32 +: 32] = (i == 0) ? ID_VALUE : regs[i];
    end

    // Lower-address offset and byte count from first_be
    logic [1:0]  lo;
    logic [12:0] byte_cnt;
    always_comb begin
        lo = 2'd0;
        casez (be_q)
            4'b???1: lo = 2'd0;
            4'b??10: lo = 2'd1;
            4'b?100: lo = 2'd2;
            4'b1000: lo = 2'd3;
            default: lo = 2'd0;
        endcase
        casez (be_q)
            4'b1??1:                   byte_cnt = 13'd4;
            4'b01?1, 4'b1?10:          byte_cnt = 13'd3;
            4'b0011, 4'b0110, 4'b1100: byte_cnt = 13'd2;
            default:                   byte_cnt = 13'd1;
        endcase
    end

    // Outputs: CQ ready, CC completion beat, error pulse
    always_comb begin
        s_axis_cq_tready   = !rst && (state == S_IDLE || state == S_DRAIN);
        m_axis_cc_tvalid   = (state == S_CPL);
        m_axis_cc_tdata    = '0;
        m_axis_cc_tkeep    = '0;
        m_axis_cc_tlast    = 1'b0;
        m_axis_cc_tuser    = '0;
        if (state == S_CPL) begin
            m_axis_cc_tlast         = 1'b1;
            m_axis_cc_tdata[63:48]  = rid_q;
            m_axis_cc_tdata[71:64]  = tag_q;
            m_axis_cc_tdata[79:72]  = func_q;
            m_axis_cc_tdata[91:89]  = tc_q;
            m_axis_cc_tdata[94:92]  = attr_q;
            if (ur_q) begin
                m_axis_cc_tdata[28:16] = 13'd4;
                m_axis_cc_tdata[45:43] = 3'b001;
                m_axis_cc_tkeep        = AXIS_PCIE_KEEP_WIDTH'(8'h07);
            end else begin
                m_axis_cc_tdata[6:0]   = {la_q, lo};
                m_axis_cc_tdata[28:16] = byte_cnt;
                m_axis_cc_tdata[42:32] = 11'd1;
                m_axis_cc_tdata[127:96] = rd_data_q;
                m_axis_cc_tkeep        = AXIS_PCIE_KEEP_WIDTH'(8'h0F);
            end
        end
    end

    assign status_error_uncor = beat0_fire && !cq_ok_wr && !cq_ok_rd;

endmodule

// File: tb/tb_pcie_us_cq_reg_completer.sv
// Bench for pcie_us_cq_reg_completer: request driver, CC scoreboard with an
// expected queue, register-file model, final report.
module tb_pcie_us_cq_reg_completer;
    localparam int          W    = 264;
    localparam logic [31:0] ID   = 32'h1234_0001;
    localparam logic [15:0] RID  = 16'hABCD;
    localparam logic [7:0]  FUNC = 8'h03;
    localparam logic [2:0]  TC   = 3'd5;
    localparam logic [2:0]  ATTR = 3'd2;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #2 clk = ~clk;

    logic [255:0] s_axis_cq_tdata = '0;
    logic [7:0]   s_axis_cq_tkeep = 8'hFF;
    logic         s_axis_cq_tlast = 1'b0;
    logic [87:0]  s_axis_cq_tuser = '0;
    logic         s_axis_cq_tvalid = 1'b0;
    logic         s_axis_cq_tready;
    logic [255:0] m_axis_cc_tdata;
    logic [7:0]   m_axis_cc_tkeep;
    logic         m_axis_cc_tlast;
    logic [32:0]  m_axis_cc_tuser;
    logic         m_axis_cc_tvalid;
    logic         m_axis_cc_tready = 1'b1;
    logic [511:0] reg_out;
    logic         status_error_uncor;

    pcie_us_cq_reg_completer dut (
        .clk(clk), .rst(rst),
        .s_axis_cq_tdata(s_axis_cq_tdata), .s_axis_cq_tkeep(s_axis_cq_tkeep),
        .s_axis_cq_tlast(s_axis_cq_tlast), .s_axis_cq_tuser(s_axis_cq_tuser),
        .s_axis_cq_tvalid(s_axis_cq_tvalid), .s_axis_cq_tready(s_axis_cq_tready),
        .m_axis_cc_tdata(m_axis_cc_tdata), .m_axis_cc_tkeep(m_axis_cc_tkeep),
        .m_axis_cc_tlast(m_axis_cc_tlast), .m_axis_cc_tuser(m_axis_cc_tuser),
        .m_axis_cc_tvalid(m_axis_cc_tvalid), .m_axis_cc_tready(m_axis_cc_tready),
        .reg_out(reg_out), .status_error_uncor(status_error_uncor)
    );

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    logic [31:0]  model_regs[16];
    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int exp_pulses = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected CC beat {tkeep, tdata}
    function automatic logic [W-1:0] cc_model(input bit ur, input logic [63:0] addr,
                                              input logic [3:0] be, input logic [31:0] data,
                                              input logic [7:0] tag);
        logic [255:0] d;
        logic [1:0]   lo;
        int first, last, bc;
        d = '0;
        first = -1;
        last  = -1;
        for (int b = 0; b < 4; b++)
            if (be[b]) begin
                if (first < 0) first = b;
                last = b;
            end
        if (first < 0) begin bc = 1; lo = 2'd0; end
        else begin bc = last - first + 1; lo = first[1:0]; end
        d[63:48] = RID; d[71:64] = tag; d[79:72] = FUNC; d[91:89] = TC; d[94:92] = ATTR;
        if (ur) begin
            d[28:16] = 13'd4;
            d[45:43] = 3'b001;
            return {8'h07, d};
        end
        d[6:0]    = {addr[6:2], lo};
        d[28:16]  = bc[12:0];
        d[42:32]  = 11'd1;
        d[127:96] = data;
        return {8'h0F, d};
    endfunction

    task automatic model_write(input int idx, input logic [3:0] be, input logic [31:0] data);
        if (idx != 0)
            for (int b = 0; b < 4; b++)
                if (be[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
    endtask

    // CC monitor / error-pulse counter, sampled on the falling edge
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && status_error_uncor) err_pulses++;
        if (m_axis_cc_tvalid && m_axis_cc_tready) begin
            if (exp_q.size() == 0) begin
                check("cc_unexpected", {m_axis_cc_tkeep, m_axis_cc_tdata}, '0);
            end else begin
                e = exp_q.pop_front();
                check("cc_beat", {m_axis_cc_tkeep, m_axis_cc_tdata}, e);
                check("cc_last_user", {m_axis_cc_tlast, m_axis_cc_tuser}, {1'b1, 33'b0});
            end
        end
    end

    // Drivers: all stimulus changes 1 time unit after a rising edge
    task automatic cq_beat(input logic [255:0] d, input logic [3:0] be, input logic last);
        int n = 0;
        s_axis_cq_tdata  = d;
        s_axis_cq_tuser  = {84'b0, be};
        s_axis_cq_tlast  = last;
        s_axis_cq_tvalid = 1'b1;
        while (!s_axis_cq_tready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("cq_accept", (n < 100), 1);
        @(posedge clk); #1;
        s_axis_cq_tvalid = 1'b0;
    endtask

    task automatic send_req(input logic [3:0] typ, input logic [63:0] addr, input logic [10:0] dw,
                            input logic [3:0] be, input logic [31:0] data, input logic [7:0] tag,
                            input int beats);
        logic [255:0] d;
        d = '0;
        d[63:2] = addr[63:2]; d[74:64] = dw; d[78:75] = typ; d[95:80] = RID;
        d[103:96] = tag; d[111:104] = FUNC; d[123:121] = TC; d[126:124] = ATTR;
        d[159:128] = data;
        cq_beat(d, be, beats == 1);
        for (int i = 1; i < beats; i++) cq_beat({8{$urandom()}}, 4'h0, i == beats - 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("cc_drain", exp_q.size(), 0);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) check(tag, reg_out[i*32 +: 32], model_regs[i]);
    endtask

    task automatic reset_model();
        model_regs[0] = ID;
        for (int i = 1; i < 16; i++) model_regs[i] = '0;
    endtask

    initial begin
        logic [W-1:0] e;
        int n;
        reset_model();

        // Reset behaviour
        @(posedge clk); #1;
        check("rst_cq_tready", s_axis_cq_tready, 0);
        check("rst_cc_tvalid", m_axis_cc_tvalid, 0);
        check("rst_err", status_error_uncor, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_regs("rst_regs");
        check("idle_cq_tready", s_axis_cq_tready, 1);

        // Read ID register, with latency check
        exp_q.push_back(cc_model(0, 64'h0, 4'hF, ID, 8'h11));
        send_req(4'b0000, 64'h0, 11'd1, 4'hF, 32'h0, 8'h11, 1);
        check("lat_n1_tvalid", m_axis_cc_tvalid, 0);
        @(posedge clk); #1;
        check("lat_n2_tvalid", m_axis_cc_tvalid, 1);
        wait_drain();

        // Write then partial read
        send_req(4'b0001, 64'h8, 11'd1, 4'hF, 32'hDEADBEEF, 8'h20, 1);
        model_write(2, 4'hF, 32'hDEADBEEF);
        check("reg2_wr", reg_out[2*32 +: 32], 32'hDEADBEEF);
        exp_q.push_back(cc_model(0, 64'h8, 4'hC, 32'hDEADBEEF, 8'h21));
        check("la_0x0a", exp_q[0][6:0], 7'h0A);
        send_req(4'b0000, 64'h8, 11'd1, 4'hC, 32'h0, 8'h21, 1);
        wait_drain();

        // Byte-enable merge and read-only reg0
        send_req(4'b0001, 64'hC, 11'd1, 4'hF, 32'h55667788, 8'h22, 1);
        send_req(4'b0001, 64'hC, 11'd1, 4'h3, 32'hAABBCCDD, 8'h23, 1);
        model_write(3, 4'hF, 32'h55667788);
        model_write(3, 4'h3, 32'hAABBCCDD);
        check("reg3_merge", reg_out[3*32 +: 32], 32'h5566CCDD);
        send_req(4'b0001, 64'h0, 11'd1, 4'hF, 32'hFFFFFFFF, 8'h24, 1);
        check("reg0_ro", reg_out[31:0], ID);

        // Unsupported: MRd dw_cnt=2 -> UR
        exp_q.push_back(cc_model(1, 64'h10, 4'hF, 32'h0, 8'h30));
        exp_pulses++;
        send_req(4'b0000, 64'h10, 11'd2, 4'hF, 32'h0, 8'h30, 1);
        wait_drain();
        check("ur_pulse", err_pulses, exp_pulses);

        // Unsupported: 2-beat MWr -> drained, no completion, no write
        exp_pulses++;
        send_req(4'b0001, 64'h8, 11'd2, 4'hF, 32'h0BADF00D, 8'h31, 2);
        repeat (4) @(posedge clk);
        #1;
        check("drain_no_write", reg_out[2*32 +: 32], 32'hDEADBEEF);
        check("drain_pulse", err_pulses, exp_pulses);

        // Unsupported type (IO read) and multi-beat MRd -> UR
        exp_q.push_back(cc_model(1, 64'h4, 4'hF, 32'h0, 8'h32));
        exp_pulses++;
        send_req(4'b0010, 64'h4, 11'd1, 4'hF, 32'h0, 8'h32, 1);
        wait_drain();
        exp_q.push_back(cc_model(1, 64'h4, 4'hF, 32'h0, 8'h33));
        exp_pulses++;
        send_req(4'b0000, 64'h4, 11'd1, 4'hF, 32'h0, 8'h33, 3);
        wait_drain();

        // Random traffic against the register model
        for (int i = 0; i < 24; i++) begin
            int idx;
            logic [3:0]  be;
            logic [31:0] data;
            logic [63:0] addr;
            idx  = $urandom_range(0, 15);
            be   = 4'($urandom_range(0, 15));
            data = $urandom();
            addr = (64'($urandom_range(0, 3)) << 6) | (64'(idx) << 2);
            if ($urandom_range(0, 1) == 1) begin
                send_req(4'b0001, addr, 11'd1, be, data, 8'(i), 1);
                model_write(idx, be, data);
            end else begin
                exp_q.push_back(cc_model(0, addr, be, model_regs[idx], 8'(i)));
                send_req(4'b0000, addr, 11'd1, be, 32'h0, 8'(i), 1);
                wait_drain();
            end
        end
        check_regs("rand_regs");

        // Backpressure on CC
        m_axis_cc_tready = 1'b0;
        e = cc_model(0, 64'hC, 4'hF, model_regs[3], 8'h40);
        exp_q.push_back(e);
        send_req(4'b0000, 64'hC, 11'd1, 4'hF, 32'h0, 8'h40, 1);
        n = 0;
        while (!m_axis_cc_tvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_cc_hold", {m_axis_cc_tkeep, m_axis_cc_tdata}, e);
            check("bp_cc_tvalid", m_axis_cc_tvalid, 1);
            check("bp_cq_tready", s_axis_cq_tready, 0);
            @(posedge clk); #1;
        end
        m_axis_cc_tready = 1'b1;
        wait_drain();
        exp_q.push_back(cc_model(0, 64'h8, 4'h1, model_regs[2], 8'h41));
        send_req(4'b0000, 64'h8, 11'd1, 4'h1, 32'h0, 8'h41, 1);
        wait_drain();

        // Reset while a completion is pending
        m_axis_cc_tready = 1'b0;
        send_req(4'b0000, 64'h8, 11'd1, 4'hF, 32'h0, 8'h50, 1);
        @(posedge clk); #1;
        check("pre_rst_tvalid", m_axis_cc_tvalid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_cpl_tvalid", m_axis_cc_tvalid, 0);
        check("rst_cpl_cq_tready", s_axis_cq_tready, 0);
        reset_model();
        check_regs("rst_cpl_regs");
        rst = 1'b0;
        m_axis_cc_tready = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(cc_model(0, 64'h8, 4'hF, 32'h0, 8'h51));
        send_req(4'b0000, 64'h8, 11'd1, 4'hF, 32'h0, 8'h51, 1);
        wait_drain();

        repeat (3) @(posedge clk);
        #1;
        check("err_pulses_total", err_pulses, exp_pulses);
        check("exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
